// File: rtl/ets_phase_sequencer_pkg.sv
// Shared types and constants for the ETS phase-shift sequencer.
// Holds the FSM state enum, default phase geometry and direction encoding.
package ets_pkg;

    localparam int POS_W_DEF         = 16;
    localparam int PS_WRAP_DEF       = 1120;
    localparam int PS_TIMEOUT_DEF    = 255;
    localparam int SETTLE_CYCLES_DEF = 16;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5,
        ST_ACK    = 3'd6
    } state_t;

endpackage

// File: rtl/ets_phase_sequencer_if.sv
// MMCM dynamic phase-shift port bundle.
// Handshake: ps_en is a one-cycle request strobe carrying ps_incdec as its
// direction; ps_done is the one-cycle completion from the MMCM. Only one step
// may be outstanding: the master issues no new ps_en until ps_done returns.
interface ets_phase_sequencer_if;
    logic ps_en;
    logic ps_incdec;
    logic ps_done;

    modport master (output ps_en, output ps_incdec, input ps_done);
    modport slave  (input ps_en, input ps_incdec, output ps_done);
endinterface

// File: rtl/ets_phase_sequencer_sync2.sv
// ets_sync2: two-flop level synchroniser for slow levels crossing from the
// sample_clk domain into the free_run_clk domain.
module ets_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Two back-to-back flops give the first stage a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ets_phase_sequencer.sv
// ets_phase_sequencer: arbitrates the MMCM phase-shift port between the ETS
// engine (4-phase shift_req/shift_done) and software manual steps, tracks the
// absolute phase modulo PS_WRAP and flags psdone timeouts.
// Optional build macro ETS_PS_SETTLE_EN inserts a SETTLE_CYCLES wait after
// every ps_done before the position update.
module ets_phase_sequencer
    import ets_pkg::*;
#(
    parameter int POS_W         = POS_W_DEF,
    parameter int PS_WRAP       = PS_WRAP_DEF,
    parameter int PS_TIMEOUT    = PS_TIMEOUT_DEF
`ifdef ETS_PS_SETTLE_EN
    ,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
`endif
) (
    input  logic                  free_run_clk,
    input  logic                  rst_n,
    input  logic                  shift_req,
    input  logic [POS_W-1:0]      step_count,
    output logic                  shift_done,
    input  logic                  man_req,
    input  logic                  man_dir,
    input  logic [POS_W-1:0]      man_steps,
    output logic                  man_busy,
    ets_phase_sequencer_if.master ps,
    output logic [POS_W-1:0]      phase_pos,
    output logic                  wrap_pulse,
    output logic                  timeout_err,
    input  logic                  err_clr,
    output state_t                dbg_state
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(PS_WRAP - 1);
    localparam logic [POS_W-1:0] TO_LAST = POS_W'(PS_TIMEOUT - 1);
`ifdef ETS_PS_SETTLE_EN
    localparam logic [POS_W-1:0] SETTLE_LAST = POS_W'(SETTLE_CYCLES - 1);
`endif

    state_t             state, next_state;
    logic               req_sync;
    logic               man_pend, man_pend_dir;
    logic [POS_W-1:0]   man_pend_steps;
    logic [POS_W-1:0]   rem_cnt, wait_cnt, pos_step;
    logic               cur_dir, cur_ets, pos_wraps;
    logic               grant_ets, grant_man, timeout_hit;

    ets_sync2 u_req_sync (
        .clk   (free_run_clk),
        .rst_n (rst_n),
        .d     (shift_req),
        .q     (req_sync)
    );

    // ETS has fixed priority; shift_done is always low in IDLE, so the synced
    // request alone qualifies a new ETS grant.
    assign grant_ets   = req_sync;
    assign grant_man   = !req_sync && man_pend;
    assign timeout_hit = (state == ST_WAIT) && !ps.ps_done && (wait_cnt == TO_LAST);
    assign man_busy    = man_pend;
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge free_run_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; ps_done only matters in WAIT, so an early pulse
    // during ISSUE is ignored by construction.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_ets)      next_state = (step_count == '0) ? ST_FINISH : ST_ISSUE;
                else if (grant_man) next_state = (man_pend_steps == '0) ? ST_FINISH : ST_ISSUE;
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
`ifdef ETS_PS_SETTLE_EN
                if (ps.ps_done)       next_state = ST_SETTLE;
`else
                if (ps.ps_done)       next_state = ST_NEXT;
`endif
                else if (timeout_hit) next_state = ST_FINISH;
            end
`ifdef ETS_PS_SETTLE_EN
            ST_SETTLE: if (wait_cnt == SETTLE_LAST) next_state = ST_NEXT;
`endif
            ST_NEXT:   next_state = (rem_cnt == POS_W'(1)) ? ST_FINISH : ST_ISSUE;
            ST_FINISH: next_state = cur_ets ? ST_ACK : ST_IDLE;
            ST_ACK:    if (!req_sync) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode: one-cycle ps_en in ISSUE, acknowledge held in ACK.
    always_comb begin
        ps.ps_en     = 1'b0;
        ps.ps_incdec = 1'b0;
        shift_done   = 1'b0;
        wrap_pulse   = 1'b0;
        case (state)
            ST_ISSUE: begin
                ps.ps_en     = 1'b1;
                ps.ps_incdec = cur_dir;
            end
            ST_NEXT: wrap_pulse = pos_wraps;
            ST_ACK:  shift_done = 1'b1;
            default: ;
        endcase
    end

    // One modular step of the phase position in the current direction.
    always_comb begin
        pos_step  = phase_pos;
        pos_wraps = 1'b0;
        if (cur_dir == DIR_INC) begin
            if (phase_pos == POS_MAX) begin
                pos_step  = '0;
                pos_wraps = 1'b1;
            end else begin
                pos_step = phase_pos + POS_W'(1);
            end
        end else begin
            if (phase_pos == '0) begin
                pos_step  = POS_MAX;
                pos_wraps = 1'b1;
            end else begin
                pos_step = phase_pos - POS_W'(1);
            end
        end
    end

    // Transaction datapath: grant capture, step countdown, position and
    // the shared WAIT/SETTLE cycle counter (restarted on every state change).
    always_ff @(posedge free_run_clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_cnt   <= '0;
            cur_dir   <= DIR_INC;
            cur_ets   <= 1'b0;
            wait_cnt  <= '0;
            phase_pos <= '0;
        end else begin
            if (state == ST_IDLE && grant_ets) begin
                rem_cnt <= step_count;
                cur_dir <= DIR_INC;
                cur_ets <= 1'b1;
            end else if (state == ST_IDLE && grant_man) begin
                rem_cnt <= man_pend_steps;
                cur_dir <= man_pend_dir;
                cur_ets <= 1'b0;
            end
            if (state == ST_NEXT) begin
                phase_pos <= pos_step;
                rem_cnt   <= rem_cnt - POS_W'(1);
            end
            if (next_state != state)                         wait_cnt <= '0;
            else if (state == ST_WAIT || state == ST_SETTLE) wait_cnt <= wait_cnt + POS_W'(1);
        end
    end

    // Single-slot manual request latch; requests while busy are dropped.
    always_ff @(posedge free_run_clk or negedge rst_n) begin
        if (!rst_n) begin
            man_pend       <= 1'b0;
            man_pend_dir   <= DIR_DEC;
            man_pend_steps <= '0;
        end else if (state == ST_FINISH && !cur_ets) begin
            man_pend <= 1'b0;
        end else if (man_req && !man_pend) begin
            man_pend       <= 1'b1;
            man_pend_dir   <= man_dir;
            man_pend_steps <= man_steps;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge free_run_clk or negedge rst_n) begin
        if (!rst_n)           timeout_err <= 1'b0;
        else if (timeout_hit) timeout_err <= 1'b1;
        else if (err_clr)     timeout_err <= 1'b0;
    end

endmodule

// File: tb/tb_ets_phase_sequencer.sv
// Bench for ets_phase_sequencer: MMCM responder, ps_en direction scoreboard,
// table of directed transactions, multi-cycle corner sequences and random
// transactions checked against an arithmetic position model.
module tb_ets_phase_sequencer;
    import ets_pkg::*;

    localparam int W   = 16;
    localparam int WRP = 1120;
    localparam int TO  = 255;
    localparam int SEL_SHIFT_DONE = 0, SEL_MAN_BUSY = 1, SEL_PS_EN = 2,
                   SEL_TIMEOUT = 3, SEL_IN_WAIT = 4;

    logic free_run_clk = 1'b0, rst_n = 1'b0;
    logic shift_req = 0, man_req = 0, man_dir = 0, err_clr = 0;
    logic [W-1:0] step_count = '0, man_steps = '0;
    logic shift_done, man_busy, wrap_pulse, timeout_err;
    logic [W-1:0] phase_pos;
    state_t dbg_state;
    logic ps_done_drv = 1'b0;

    ets_phase_sequencer_if psif ();
    assign psif.ps_done = ps_done_drv;

    ets_phase_sequencer dut (
        .free_run_clk (free_run_clk), .rst_n (rst_n),
        .shift_req (shift_req), .step_count (step_count), .shift_done (shift_done),
        .man_req (man_req), .man_dir (man_dir), .man_steps (man_steps), .man_busy (man_busy),
        .ps (psif.master), .phase_pos (phase_pos), .wrap_pulse (wrap_pulse),
        .timeout_err (timeout_err), .err_clr (err_clr), .dbg_state (dbg_state)
    );

    // Clock
    always #5 free_run_clk = ~free_run_clk;

    int checks = 0, errors = 0;
    int en_cnt = 0, inc_cnt = 0, wrap_cnt = 0, overlap_cnt = 0;
    int mmcm_cd = 0, done_delay = 5;
    bit withhold = 0;
    int ref_pos = 0;
    logic [0:0] exp_q[$];
    logic [0:0] exp_dir;

    typedef struct {
        bit is_ets; bit dir; int steps; int dly;
        int exp_pos; int exp_en; int exp_inc; int exp_wrap;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            SEL_SHIFT_DONE: return shift_done;
            SEL_MAN_BUSY:   return man_busy;
            SEL_PS_EN:      return psif.ps_en;
            SEL_TIMEOUT:    return timeout_err;
            default:        return logic'(dbg_state == ST_WAIT);
        endcase
    endfunction

    // Bounded wait on a DUT signal, sampled on falling edges.
    task automatic wait_for(input int sel, input logic val, input int budget,
                            input string name, output int n);
        n = 0;
        while (sig_sel(sel) !== val && n < budget) begin
            @(negedge free_run_clk);
            n++;
        end
        checks++;
        if (sig_sel(sel) !== val) begin
            errors++;
            $display("FAIL %s actual=not_seen_in_%0d_cycles required=%0d", name, n, val);
        end
    endtask

    // Reference: move pos by steps in dir modulo WRP, counting boundary crossings.
    task automatic ref_move(input int pos, input bit dir, input int steps,
                            output int np, output int wraps);
        if (dir) begin
            wraps = (pos + steps) / WRP;
            np    = (pos + steps) % WRP;
        end else begin
            wraps = (steps > pos) ? ((steps - pos - 1) / WRP + 1) : 0;
            np    = ((pos - steps) % WRP + WRP) % WRP;
        end
    endtask

    // MMCM responder and ps_en scoreboard.
    always @(negedge free_run_clk) begin
        ps_done_drv = 1'b0;
        if (!rst_n) begin
            mmcm_cd = 0;
        end else begin
            if (mmcm_cd > 0) begin
                mmcm_cd--;
                if (mmcm_cd == 0) ps_done_drv = 1'b1;
            end
            if (psif.ps_en) begin
                if (mmcm_cd > 0) overlap_cnt++;
                en_cnt++;
                if (psif.ps_incdec) inc_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ps_en actual=ps_en_dir_%0d required=no_ps_en", psif.ps_incdec);
                end else begin
                    exp_dir = exp_q.pop_front();
                    if (psif.ps_incdec !== exp_dir) begin
                        errors++;
                        $display("FAIL sb_ps_incdec actual=%0d required=%0d", psif.ps_incdec, exp_dir);
                    end
                end
                if (!withhold) mmcm_cd = done_delay;
            end
            if (wrap_pulse) wrap_cnt++;
        end
    end

    // One complete ETS or manual transaction with its expected effects.
    task automatic run_txn(input bit is_ets, input bit dir, input int steps, input int dly,
                           input int exp_pos, input int exp_en, input int exp_inc,
                           input int exp_wrap, input string tag);
        int e0, i0, w0, n;
        e0 = en_cnt; i0 = inc_cnt; w0 = wrap_cnt;
        done_delay = dly;
        for (int k = 0; k < steps; k++) exp_q.push_back(dir);
        if (is_ets) begin
            step_count = W'(steps);
            shift_req  = 1'b1;
            if (steps > 0) begin
                wait_for(SEL_PS_EN, 1'b1, 20, {tag, "_first_ps_en"}, n);
                check({tag, "_req_to_ps_en_cycles"}, n, 3);
                wait_for(SEL_SHIFT_DONE, 1'b1, 4000, {tag, "_shift_done_rise"}, n);
            end else begin
                wait_for(SEL_SHIFT_DONE, 1'b1, 5, {tag, "_zero_step_ack_within_5"}, n);
            end
            shift_req = 1'b0;
            wait_for(SEL_SHIFT_DONE, 1'b0, 10, {tag, "_shift_done_fall"}, n);
        end else begin
            man_dir = dir; man_steps = W'(steps); man_req = 1'b1;
            @(negedge free_run_clk);
            man_req = 1'b0;
            check({tag, "_man_busy_set"}, man_busy, 1);
            wait_for(SEL_MAN_BUSY, 1'b0, 4000, {tag, "_man_busy_drop"}, n);
        end
        @(negedge free_run_clk);
        check({tag, "_phase_pos"}, phase_pos, exp_pos);
        check({tag, "_ps_en_count"}, en_cnt - e0, exp_en);
        check({tag, "_inc_count"}, inc_cnt - i0, exp_inc);
        check({tag, "_wrap_count"}, wrap_cnt - w0, exp_wrap);
    endtask

    initial begin
        int n, e0, np, nw, steps, dly;
        bit is_ets, dir;

        vecs[0] = '{1, 1, 3, 5,    3, 3, 3, 0};
        vecs[1] = '{0, 0, 3, 2,    0, 3, 0, 0};
        vecs[2] = '{0, 0, 2, 5, 1118, 2, 0, 1};
        vecs[3] = '{1, 1, 3, 1,    1, 3, 3, 1};
        vecs[4] = '{0, 1, 0, 1,    1, 0, 0, 0};
        vecs[5] = '{1, 1, 0, 1,    1, 0, 0, 0};
        vecs[6] = '{0, 1, 4, 3,    5, 4, 4, 0};

        // Reset values
        repeat (3) @(negedge free_run_clk);
        check("rst_shift_done", shift_done, 0);
        check("rst_man_busy", man_busy, 0);
        check("rst_ps_en", psif.ps_en, 0);
        check("rst_ps_incdec", psif.ps_incdec, 0);
        check("rst_wrap_pulse", wrap_pulse, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_phase_pos", phase_pos, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge free_run_clk);

        // Directed table
        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].is_ets, vecs[v].dir, vecs[v].steps, vecs[v].dly, vecs[v].exp_pos,
                    vecs[v].exp_en, vecs[v].exp_inc, vecs[v].exp_wrap, $sformatf("vec%0d", v));
        end
        ref_pos = 5;

        // man_req together with the first synchronised shift_req: ETS first.
        e0 = en_cnt; done_delay = 3; step_count = 3;
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b1);
        for (int k = 0; k < 2; k++) exp_q.push_back(1'b0);
        shift_req = 1'b1;
        repeat (2) @(negedge free_run_clk);
        man_dir = 1'b0; man_steps = 2; man_req = 1'b1;
        @(negedge free_run_clk);
        man_req = 1'b0;
        check("arb_man_busy_pending", man_busy, 1);
        wait_for(SEL_SHIFT_DONE, 1'b1, 200, "arb_shift_done", n);
        check("arb_ets_steps_first", en_cnt - e0, 3);
        check("arb_man_still_busy", man_busy, 1);
        shift_req = 1'b0;
        wait_for(SEL_MAN_BUSY, 1'b0, 200, "arb_man_done", n);
        @(negedge free_run_clk);
        check("arb_total_ps_en", en_cnt - e0, 5);
        check("arb_phase_pos", phase_pos, 6);
        ref_pos = 6;

        // Withheld ps_done: timeout, ETS still acknowledged, remaining step dropped.
        withhold = 1; e0 = en_cnt; step_count = 2;
        exp_q.push_back(1'b1);
        shift_req = 1'b1;
        wait_for(SEL_PS_EN, 1'b1, 20, "to_first_ps_en", n);
        wait_for(SEL_TIMEOUT, 1'b1, 400, "to_timeout_err_set", n);
        checks++;
        if (n < TO || n > TO + 2) begin
            errors++;
            $display("FAIL to_latency actual=%0d required=%0d..%0d", n, TO, TO + 2);
        end
        wait_for(SEL_SHIFT_DONE, 1'b1, 10, "to_shift_done", n);
        check("to_phase_pos_unchanged", phase_pos, ref_pos);
        check("to_single_ps_en", en_cnt - e0, 1);
        shift_req = 1'b0;
        wait_for(SEL_SHIFT_DONE, 1'b0, 10, "to_shift_done_fall", n);
        check("to_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge free_run_clk);
        err_clr = 1'b0;
        check("to_err_clr", timeout_err, 0);

        // Timeout while err_clr is held: the set must win.
        err_clr = 1'b1; step_count = 1;
        exp_q.push_back(1'b1);
        shift_req = 1'b1;
        wait_for(SEL_TIMEOUT, 1'b1, 400, "to_set_beats_clr", n);
        err_clr = 1'b0;
        wait_for(SEL_SHIFT_DONE, 1'b1, 10, "to2_shift_done", n);
        shift_req = 1'b0;
        wait_for(SEL_SHIFT_DONE, 1'b0, 10, "to2_shift_done_fall", n);
        check("to2_still_set", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge free_run_clk);
        err_clr = 1'b0;
        withhold = 0;
        check("to2_err_clr", timeout_err, 0);

        // Random transactions against the arithmetic model.
        for (int r = 0; r < 20; r++) begin
            is_ets = 1'($urandom_range(0, 1));
            dir    = is_ets ? 1'b1 : 1'($urandom_range(0, 1));
            steps  = $urandom_range(0, 9);
            dly    = $urandom_range(1, 4);
            ref_move(ref_pos, dir, steps, np, nw);
            run_txn(is_ets, dir, steps, dly, np, steps, dir ? steps : 0, nw,
                    $sformatf("rnd%0d", r));
            ref_pos = np;
        end

        // Reset asserted in WAIT aborts at once; nothing issues afterwards.
        done_delay = 20;
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b1);
        man_dir = 1'b1; man_steps = 3; man_req = 1'b1;
        @(negedge free_run_clk);
        man_req = 1'b0;
        wait_for(SEL_IN_WAIT, 1'b1, 20, "rstw_reach_wait", n);
        rst_n = 1'b0;
        #1;
        check("rstw_ps_en", psif.ps_en, 0);
        check("rstw_ps_incdec", psif.ps_incdec, 0);
        check("rstw_man_busy", man_busy, 0);
        check("rstw_shift_done", shift_done, 0);
        check("rstw_wrap_pulse", wrap_pulse, 0);
        check("rstw_phase_pos", phase_pos, 0);
        exp_q.delete();
        mmcm_cd = 0;
        repeat (2) @(negedge free_run_clk);
        rst_n = 1'b1;
        e0 = en_cnt;
        repeat (30) @(negedge free_run_clk);
        check("rstw_no_ps_en_after_release", en_cnt - e0, 0);
        check("rstw_idle", int'(dbg_state), int'(ST_IDLE));

        check("sb_queue_drained", exp_q.size(), 0);
        check("no_overlapping_ps_en", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
